stream_index_generator: RTL and testbench
=========================================

# stream_index_generator

Sequencing front end for a memory port: on a start pulse it streams a strided sequence of read indices into the memory's read-index link and collects the returned words. It forwards those words in order to a consumer link. It limits in-flight reads with a credit counter and reports quiescence to the enclosing system. It sits directly upstream of the memory read port, drives its index link, and consumes its data link.

## Interface
- MAX_OUTSTANDING, 4, max indices issued but not yet forwarded on data_output_link; also the data FIFO depth (power of two, >= 2)
- Word width is TIA_WORD_WIDTH (W) throughout.
- clock  input  1  single clock, positive-edge triggered
- reset  input  1  asynchronous, active-low; all state cleared while low
- enable  input  1  active high; when low, state frozen, all req/ack outputs forced 0
- start  input  1  one-cycle launch pulse; honoured only in IDLE
- base  input  W  first index, sampled on accepted start
- stride  input  W  index increment, sampled on accepted start
- count  input  W  number of indices, sampled on accepted start
- index_output_link  link_if.sender  W  indices to the memory read-index link
- data_input_link  link_if.receiver  W  words returned by the memory read-data link
- data_output_link  link_if.sender  W  in-order words to the consumer
- busy  output  1  high in ISSUE and DRAIN
- done  output  1  one-cycle completion pulse
- quiescent  output  1  registered; high when IDLE and data FIFO empty

## Operation
- Link rule: a transfer occurs on a cycle where req and ack are both high. Data is stable while req is high and ack is low.
- Internal counters (W bits each):
  - issued: index transfers this job
  - forwarded: output transfers this job
  - outstanding: issued minus forwarded, width clog2(MAX_OUTSTANDING)+1
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On start: latch base/stride/count, clear issued/forwarded, set next_index = base.
  - If count != 0, go to ISSUE; if count == 0, go to DONE.
- ISSUE:
  - index_output_link.req = enable && issued < count && outstanding < MAX_OUTSTANDING; data = next_index.
  - On index transfer: next_index += stride (modulo 2^W, wrap silent), issued++.
  - Go to DRAIN on the edge where issued reaches count.
- DRAIN: no index requests. Go to DONE on the edge where forwarded reaches count.
- ISSUE also goes directly to DONE if forwarded reaches count on the same edge as the final issue (count reachable with MAX_OUTSTANDING >= 1 only via DRAIN; the transition is kept for safety).
- DONE: done = 1 for one cycle, then IDLE.
- outstanding: +1 on index transfer, -1 on output transfer. Both on the same cycle leave it unchanged.
- Data FIFO, depth MAX_OUTSTANDING, circular, pointer wrap at depth:
  - data_input_link.ack = enable && !fifo_full.
  - data_output_link.req = enable && !fifo_empty; data = FIFO head.
  - The credit limit guarantees the FIFO never overflows. A push while full is a design error and is flagged by an assertion.
  - Simultaneous push and pop on a full or empty FIFO are both legal when the respective handshake permits.
- start outside IDLE is ignored, with no effect on the latched parameters.
- Stray data received in IDLE is forwarded but does not count toward any job.

## Timing
- Reset (async assert) values:
  - state IDLE; all counters and FIFO pointers 0
  - every req/ack output 0
  - busy 0, done 0, quiescent 0
- quiescent is registered. It first rises on the first enabled edge after reset deasserts.
- Start accepted at edge t: busy and index req high from cycle t+1, with data = base.
- With ack held high, one index per cycle.
- Data accepted at edge t appears on data_output_link from cycle t+1. FIFO latency is 1; no combinational input-to-output path.
- Last output transfer at edge t: DONE in cycle t+1 (done=1, busy=0); IDLE at t+2.
- count == 0: start at t, done at t+1, no link activity.
- Reset asserted mid-job: job abandoned immediately, FIFO contents discarded, outputs at reset values.
- Enable low mid-job: counters, FIFO, and state held; resumes unchanged when enable returns.

## Test plan
- Basic stream: base=16, stride=4, count=5, all acks high, memory returns after 1 cycle -> indices 16,20,24,28,32 on consecutive cycles; 5 words forwarded in order; done pulses once; busy low after.
- Credit limit: MAX_OUTSTANDING=4, count=10, data_output ack held 0 -> exactly 4 indices issued, then index req stays 0. Release ack -> remaining 6 issued; done after 10 outputs.
- Wrap-around: W=32, base=0xFFFFFFFE, stride=1, count=4 -> indices 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Zero count and ignored start: start with count=0 -> done at t+1, no req. A start pulse during ISSUE -> no change to sequence or latched count.
- Backpressure and simultaneity: random ack on all three links for count=64 -> output sequence equals memory contents at base+k·stride. No FIFO overflow assertion. Outstanding never exceeds 4.
- Reset/enable: async reset low mid-DRAIN -> all outputs 0 same cycle; quiescent 1 one enabled edge after release. Enable low for 5 cycles mid-ISSUE -> no transfers, resumes at the held next_index.

Source files
------------

// File: rtl/stream_index_generator.sv
// stream_index_generator
// Front end for a memory read port. A start pulse launches a strided
// sequence of read indices toward the memory; returned words are buffered
// in a small circular FIFO and forwarded in order to the consumer. A credit
// counter caps the number of indices that have been issued but not yet
// forwarded, which also bounds FIFO occupancy.
//
// Links are flattened req/ack/data triples. A transfer happens on any edge
// where req and ack are both high.

module stream_index_generator #(
    parameter int TIA_WORD_WIDTH  = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      start,
    input  logic [TIA_WORD_WIDTH-1:0] base,
    input  logic [TIA_WORD_WIDTH-1:0] stride,
    input  logic [TIA_WORD_WIDTH-1:0] count,

    output logic                      index_output_link_req,
    input  logic                      index_output_link_ack,
    output logic [TIA_WORD_WIDTH-1:0] index_output_link_data,

    input  logic                      data_input_link_req,
    output logic                      data_input_link_ack,
    input  logic [TIA_WORD_WIDTH-1:0] data_input_link_data,

    output logic                      data_output_link_req,
    input  logic                      data_output_link_ack,
    output logic [TIA_WORD_WIDTH-1:0] data_output_link_data,

    output logic                      busy,
    output logic                      done,
    output logic                      quiescent
);

    localparam int W     = TIA_WORD_WIDTH;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int OUT_W = PTR_W + 1;

    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Sequencer state
    state_t             state_q, state_d;
    logic [W-1:0]       next_index_q, next_index_d;
    logic [W-1:0]       stride_q, stride_d;
    logic [W-1:0]       count_q, count_d;
    logic [W-1:0]       issued_q, issued_d;
    logic [W-1:0]       forwarded_q, forwarded_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic               quiescent_q, quiescent_d;

    // Data FIFO state
    logic [W-1:0]       fifo_mem_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OUT_W-1:0]   fill_q, fill_d;

    // Handshake helpers
    logic               active;
    logic               fifo_full;
    logic               fifo_empty;
    logic               idx_xfer;
    logic               push;
    logic               pop;
    logic               job_active;
    logic               job_pop;

    // Link handshakes; everything is forced low while disabled or in reset
    always_comb begin
        active     = enable && reset;
        fifo_full  = (fill_q == MAX_OUT);
        fifo_empty = (fill_q == '0);
        job_active = (state_q == ISSUE) || (state_q == DRAIN);

        index_output_link_req  = active && (state_q == ISSUE) &&
                                 (issued_q < count_q) &&
                                 (outstanding_q < MAX_OUT);
        index_output_link_data = next_index_q;

        data_input_link_ack    = active && !fifo_full;

        data_output_link_req   = active && !fifo_empty;
        data_output_link_data  = fifo_mem_q[rd_ptr_q];

        idx_xfer = index_output_link_req && index_output_link_ack;
        push     = data_input_link_req && data_input_link_ack;
        pop      = data_output_link_req && data_output_link_ack;
        // Words popped outside a job are strays and do not count toward it
        job_pop  = pop && job_active;
    end

    // Status outputs decoded from the registered state
    always_comb begin
        busy      = (state_q == ISSUE) || (state_q == DRAIN);
        done      = (state_q == DONE);
        quiescent = quiescent_q;
    end

    // FIFO pointer and fill bookkeeping; depth is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + OUT_W'(1);
            2'b01:   fill_d = fill_q - OUT_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    // Sequencer next-state, counters and credit tracking; frozen while disabled
    always_comb begin
        state_d       = state_q;
        next_index_d  = next_index_q;
        stride_d      = stride_q;
        count_d       = count_q;
        issued_d      = issued_q;
        forwarded_d   = forwarded_q;
        outstanding_d = outstanding_q;

        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        next_index_d  = base;
                        stride_d      = stride;
                        count_d       = count;
                        issued_d      = '0;
                        forwarded_d   = '0;
                        outstanding_d = '0;
                        state_d       = (count != '0) ? ISSUE : DONE;
                    end
                end

                ISSUE, DRAIN: begin
                    if (idx_xfer) begin
                        next_index_d = next_index_q + stride_q;
                        issued_d     = issued_q + W'(1);
                    end
                    if (job_pop) begin
                        forwarded_d = forwarded_q + W'(1);
                    end
                    case ({idx_xfer, job_pop})
                        2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
                        2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
                        default: outstanding_d = outstanding_q;
                    endcase

                    if (state_q == ISSUE) begin
                        if (issued_d == count_q) begin
                            state_d = (forwarded_d == count_q) ? DONE : DRAIN;
                        end
                    end else begin
                        if (forwarded_d == count_q) begin
                            state_d = DONE;
                        end
                    end
                end

                DONE: begin
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Quiescence looks at where the machine lands this edge so it tracks the current cycle
    always_comb begin
        quiescent_d = quiescent_q;
        if (enable) begin
            quiescent_d = (state_d == IDLE) && (fill_d == '0);
        end
    end

    // Control and counter registers with asynchronous active-low clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            next_index_q  <= '0;
            stride_q      <= '0;
            count_q       <= '0;
            issued_q      <= '0;
            forwarded_q   <= '0;
            outstanding_q <= '0;
            quiescent_q   <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= '0;
        end else begin
            state_q       <= state_d;
            next_index_q  <= next_index_d;
            stride_q      <= stride_d;
            count_q       <= count_d;
            issued_q      <= issued_d;
            forwarded_q   <= forwarded_d;
            outstanding_q <= outstanding_d;
            quiescent_q   <= quiescent_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fill_q        <= fill_d;
        end
    end

    // FIFO storage; contents are meaningless once the pointers are cleared, so no reset
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= data_input_link_data;
        end
    end

    // The credit limit must keep the FIFO from ever being pushed while full
    a_no_fifo_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(push && fifo_full));

    // In-flight indices never exceed the credit limit
    a_credit_bound: assert property (@(posedge clock) disable iff (!reset)
        outstanding_q <= MAX_OUT);

endmodule

// File: tb/tb_stream_index_generator.sv
// Directed testbench for stream_index_generator with a one-cycle memory model.

module tb_stream_index_generator;

    localparam int W    = 32;
    localparam int MAXO = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  base = '0;
    logic [W-1:0]  stride = '0;
    logic [W-1:0]  count = '0;

    logic          index_output_link_req;
    logic          index_output_link_ack = 1'b0;
    logic [W-1:0]  index_output_link_data;
    logic          data_input_link_req = 1'b0;
    logic          data_input_link_ack;
    logic [W-1:0]  data_input_link_data = '0;
    logic          data_output_link_req;
    logic          data_output_link_ack = 1'b0;
    logic [W-1:0]  data_output_link_data;
    logic          busy;
    logic          done;
    logic          quiescent;

    stream_index_generator #(
        .TIA_WORD_WIDTH (W),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .enable                (enable),
        .start                 (start),
        .base                  (base),
        .stride                (stride),
        .count                 (count),
        .index_output_link_req (index_output_link_req),
        .index_output_link_ack (index_output_link_ack),
        .index_output_link_data(index_output_link_data),
        .data_input_link_req   (data_input_link_req),
        .data_input_link_ack   (data_input_link_ack),
        .data_input_link_data  (data_input_link_data),
        .data_output_link_req  (data_output_link_req),
        .data_output_link_ack  (data_output_link_ack),
        .data_output_link_data (data_output_link_data),
        .busy                  (busy),
        .done                  (done),
        .quiescent             (quiescent)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    // 0: ack always high, 1: random, 2: held low
    int idx_mode = 0;
    int mem_mode = 0;
    int out_mode = 0;

    logic [W-1:0] mem_pend[$];
    logic [W-1:0] idx_log[$];
    logic [W-1:0] out_log[$];
    int           idx_cyc[$];
    int           cycle_cnt    = 0;
    int           out_last_cyc = 0;
    int           done_cyc     = 0;
    int           done_count   = 0;
    int           max_outst    = 0;
    int           en_low_xfers = 0;
    int           outst_now    = 0;
    logic         in_popped    = 1'b0;

    // Contents of the modelled memory at a given index
    function automatic logic [W-1:0] mem_word(input logic [W-1:0] idx);
        return (idx * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Records every transfer on the active edge and feeds the memory model
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_pend.delete();
            in_popped = 1'b0;
        end else begin
            if (data_input_link_req && data_input_link_ack) begin
                void'(mem_pend.pop_front());
                in_popped = 1'b1;
            end else begin
                in_popped = 1'b0;
            end
            if (index_output_link_req && index_output_link_ack) begin
                mem_pend.push_back(index_output_link_data);
                idx_log.push_back(index_output_link_data);
                idx_cyc.push_back(cycle_cnt);
            end
            if (data_output_link_req && data_output_link_ack) begin
                out_log.push_back(data_output_link_data);
                out_last_cyc = cycle_cnt;
            end
            if (done) begin
                done_count++;
                done_cyc = cycle_cnt;
            end
            if (!enable && ((index_output_link_req && index_output_link_ack) ||
                            (data_input_link_req && data_input_link_ack) ||
                            (data_output_link_req && data_output_link_ack))) begin
                en_low_xfers++;
            end
            outst_now = int'(idx_log.size()) - int'(out_log.size());
            if (outst_now > max_outst) begin
                max_outst = outst_now;
            end
            cycle_cnt++;
        end
    end

    // Drives acks and returned memory words away from the active edge
    always @(negedge clock) begin
        case (idx_mode)
            0:       index_output_link_ack = 1'b1;
            1:       index_output_link_ack = ($urandom_range(0, 1) == 1);
            default: index_output_link_ack = 1'b0;
        endcase
        case (out_mode)
            0:       data_output_link_ack = 1'b1;
            1:       data_output_link_ack = ($urandom_range(0, 1) == 1);
            default: data_output_link_ack = 1'b0;
        endcase
        if (!reset || mem_pend.size() == 0) begin
            data_input_link_req = 1'b0;
        end else begin
            data_input_link_req  = (data_input_link_req && !in_popped) || (mem_mode == 0) ||
                                   ($urandom_range(0, 1) == 1);
            data_input_link_data = mem_word(mem_pend[0]);
        end
    end

    task automatic applyStimulus(input logic [W-1:0] b, input logic [W-1:0] s, input logic [W-1:0] c);
        @(negedge clock);
        idx_log.delete();
        out_log.delete();
        idx_cyc.delete();
        max_outst = 0;
        base   = b;
        stride = s;
        count  = c;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int  start_cnt;
        bit  seen;
        start_cnt = done_count;
        seen      = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done_count != start_cnt) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    task automatic checkSequence(input string tag, input logic [W-1:0] b, input logic [W-1:0] s, input int c);
        checkOutput({tag, "_idx_count"}, 32'(idx_log.size()), 32'(c));
        checkOutput({tag, "_out_count"}, 32'(out_log.size()), 32'(c));
        for (int k = 0; k < int'(idx_log.size()) && k < c; k++) begin
            checkOutput({tag, "_idx"}, idx_log[k], b + 32'(k) * s);
        end
        for (int k = 0; k < int'(out_log.size()) && k < c; k++) begin
            checkOutput({tag, "_out"}, out_log[k], mem_word(b + 32'(k) * s));
        end
    endtask

    initial begin
        int dc0;
        int n0;
        int x0;

        #2 reset = 1'b0;
        repeat (3) @(negedge clock);

        // Reset values
        checkOutput("rst_idx_req",   32'(index_output_link_req), 32'd0);
        checkOutput("rst_in_ack",    32'(data_input_link_ack),   32'd0);
        checkOutput("rst_out_req",   32'(data_output_link_req),  32'd0);
        checkOutput("rst_busy",      32'(busy),                  32'd0);
        checkOutput("rst_done",      32'(done),                  32'd0);
        checkOutput("rst_quiescent", 32'(quiescent),             32'd0);
        reset = 1'b1;
        #1 checkOutput("quiescent_before_edge", 32'(quiescent), 32'd0);
        @(posedge clock);
        #1 checkOutput("quiescent_after_edge", 32'(quiescent), 32'd1);

        // Basic stream
        dc0 = done_count;
        applyStimulus(32'd16, 32'd4, 32'd5);
        checkOutput("basic_busy_t1", 32'(busy), 32'd1);
        checkOutput("basic_req_t1",  32'(index_output_link_req), 32'd1);
        checkOutput("basic_data_t1", index_output_link_data, 32'd16);
        waitDone("basic_done_seen", 100);
        checkSequence("basic", 32'd16, 32'd4, 5);
        checkOutput("basic_consecutive",
                    (idx_cyc.size() == 5) ? 32'(idx_cyc[4] - idx_cyc[0]) : 32'hFFFF_FFFF, 32'd4);
        checkOutput("basic_done_latency", 32'(done_cyc - out_last_cyc), 32'd1);
        checkOutput("basic_busy_after", 32'(busy), 32'd0);
        checkOutput("basic_quiescent_after", 32'(quiescent), 32'd1);
        repeat (3) @(negedge clock);
        checkOutput("basic_done_once", 32'(done_count - dc0), 32'd1);

        // Credit limit
        out_mode = 2;
        applyStimulus(32'd100, 32'd3, 32'd10);
        repeat (20) @(negedge clock);
        checkOutput("credit_issued_4", 32'(idx_log.size()), 32'd4);
        checkOutput("credit_req_low", 32'(index_output_link_req), 32'd0);
        checkOutput("credit_out_pending", 32'(data_output_link_req), 32'd1);
        out_mode = 0;
        waitDone("credit_done_seen", 200);
        checkSequence("credit", 32'd100, 32'd3, 10);
        checkOutput("credit_max_outst", 32'(max_outst), 32'd4);

        // Index wrap-around
        applyStimulus(32'hFFFF_FFFE, 32'd1, 32'd4);
        waitDone("wrap_done_seen", 100);
        checkSequence("wrap", 32'hFFFF_FFFE, 32'd1, 4);

        // Zero count
        dc0 = done_count;
        applyStimulus(32'd5, 32'd1, 32'd0);
        checkOutput("zero_done_t1", 32'(done), 32'd1);
        checkOutput("zero_busy_t1", 32'(busy), 32'd0);
        checkOutput("zero_req_t1",  32'(index_output_link_req), 32'd0);
        @(negedge clock);
        checkOutput("zero_done_t2", 32'(done), 32'd0);
        checkOutput("zero_no_idx",  32'(idx_log.size()), 32'd0);
        checkOutput("zero_done_once", 32'(done_count - dc0), 32'd1);

        // Start during ISSUE is ignored
        applyStimulus(32'd200, 32'd5, 32'd6);
        @(negedge clock);
        base   = 32'd7;
        stride = 32'd1;
        count  = 32'd1;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        waitDone("ignored_done_seen", 100);
        checkSequence("ignored", 32'd200, 32'd5, 6);

        // Random backpressure on all links
        idx_mode = 1;
        mem_mode = 1;
        out_mode = 1;
        applyStimulus(32'h0000_1000, 32'd8, 32'd64);
        waitDone("rand_done_seen", 3000);
        checkSequence("rand", 32'h0000_1000, 32'd8, 64);
        checkOutput("rand_outst_le_max", 32'(max_outst <= MAXO), 32'd1);
        idx_mode = 0;
        mem_mode = 0;
        out_mode = 0;

        // Enable low mid-ISSUE
        applyStimulus(32'd300, 32'd2, 32'd12);
        @(negedge clock);
        @(negedge clock);
        enable = 1'b0;
        n0 = int'(idx_log.size());
        x0 = en_low_xfers;
        repeat (5) @(negedge clock);
        checkOutput("en_low_no_issue", 32'(idx_log.size()), 32'(n0));
        checkOutput("en_low_no_xfers", 32'(en_low_xfers - x0), 32'd0);
        checkOutput("en_low_req_low", 32'(index_output_link_req), 32'd0);
        checkOutput("en_low_busy_held", 32'(busy), 32'd1);
        enable = 1'b1;
        #1 checkOutput("en_resume_data", index_output_link_data, 32'd300 + 32'(n0) * 32'd2);
        waitDone("en_done_seen", 200);
        checkSequence("en", 32'd300, 32'd2, 12);

        // Asynchronous reset mid-DRAIN
        out_mode = 2;
        applyStimulus(32'd400, 32'd1, 32'd3);
        repeat (10) @(negedge clock);
        checkOutput("drain_busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_idx_req",   32'(index_output_link_req), 32'd0);
        checkOutput("arst_in_ack",    32'(data_input_link_ack),   32'd0);
        checkOutput("arst_out_req",   32'(data_output_link_req),  32'd0);
        checkOutput("arst_busy",      32'(busy),                  32'd0);
        checkOutput("arst_done",      32'(done),                  32'd0);
        checkOutput("arst_quiescent", 32'(quiescent),             32'd0);
        @(negedge clock);
        reset    = 1'b1;
        out_mode = 0;
        #1 checkOutput("arst_quiescent_pre_edge", 32'(quiescent), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("arst_quiescent_post_edge", 32'(quiescent), 32'd1);
        checkOutput("arst_fifo_discarded", 32'(data_output_link_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
